mips_run_monitor: RTL

Synthesizable run controller and monitor that sits beside mips_top. It owns the CPU reset and holds the core in reset for a programmable number of cycles. It then watches pc_current and data-memory traffic until a parametrised halt PC or a cycle timeout occurs. At the end it reports cycle and store counts plus a pass/fail check on one memory word, which allows unattended runs on a bench or on hardware.

---
 rtl/mips_run_pkg.sv | 21 ++
 rtl/mips_store_log.sv | 66 ++++++
 rtl/mips_run_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_run_pkg.sv
// Shared types and helpers for the MIPS run controller/monitor.
package mips_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam logic [31:0] DEFAULT_HALT_PC = 32'h88;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_store_log.sv
// Ring buffer of the most recent counted data-memory stores; index 0 reads the newest entry.
module mips_store_log #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_addr,
  output logic [31:0]      rd_data
);

  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("mips_store_log: DEPTH must be a power of two");
  end

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] rd_ptr;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wptr_d = wptr_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_d[i] = '0;
        data_d[i] = '0;
      end
      wptr_d = '0;
    end else if (we) begin
      addr_d[wptr_q] = wr_addr;
      data_d[wptr_q] = wr_data;
      wptr_d = wptr_q + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wptr_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wptr_q <= wptr_d;
    end
  end

  // Newest entry sits just behind the write pointer; wrap is free at power-of-two depth.
  assign rd_ptr  = wptr_q - IDX_ONE - rd_idx;
  assign rd_addr = addr_q[rd_ptr];
  assign rd_data = data_q[rd_ptr];

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller/monitor beside mips_top: owns cpu_rst, counts cycles/stores, reports halt/timeout/pass.
// Optional store log built when STORE_LOG_EN is defined.
module mips_run_monitor
  import mips_run_pkg::*;
#(
  parameter logic [31:0] HALT_PC      = DEFAULT_HALT_PC,
  parameter int          RST_CYCLES   = 1,
  parameter int          MAX_CYCLES   = 1024,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] CHECK_ADDR   = 32'h0,
  parameter logic [31:0] CHECK_DATA   = 32'h0,
  parameter int          CHECK_ENABLE = 1,
  parameter int          LOG_DEPTH    = 8,
  localparam int         LOG_IDX_W    = (clog2(LOG_DEPTH) > 0) ? clog2(LOG_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          pc_current,
  input  logic                 we_dm,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          wd_dm,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic                 pass,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     store_count,
  output logic [31:0]          last_st_addr,
  output logic [31:0]          last_st_data,
  input  logic [LOG_IDX_W-1:0] log_idx,
  output logic [31:0]          log_addr,
  output logic [31:0]          log_data
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]      RST_LOAD = 32'(RST_CYCLES - 1);

  if (MAX_CYCLES < 1) begin : g_bad_max
    $error("mips_run_monitor: MAX_CYCLES must be at least 1");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("mips_run_monitor: RST_CYCLES must be at least 1");
  end

  run_state_e       state_q, state_d;
  logic [31:0]      rst_cnt_q, rst_cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;
  logic [31:0]      last_st_addr_q, last_st_addr_d;
  logic [31:0]      last_st_data_q, last_st_data_d;
  logic             chk_seen_q, chk_seen_d;
  logic [31:0]      chk_data_q, chk_data_d;
  logic             log_we, log_clr;

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    done_d         = done_q;
    halted_d       = halted_q;
    timeout_d      = timeout_q;
    pass_d         = pass_q;
    cycle_count_d  = cycle_count_q;
    store_count_d  = store_count_q;
    last_st_addr_d = last_st_addr_q;
    last_st_data_d = last_st_data_q;
    chk_seen_d     = chk_seen_q;
    chk_data_d     = chk_data_q;
    log_we         = 1'b0;
    log_clr        = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (start) begin
          state_d        = ST_RST;
          rst_cnt_d      = RST_LOAD;
          done_d         = 1'b0;
          halted_d       = 1'b0;
          timeout_d      = 1'b0;
          pass_d         = 1'b0;
          cycle_count_d  = '0;
          store_count_d  = '0;
          last_st_addr_d = '0;
          last_st_data_d = '0;
          chk_seen_d     = 1'b0;
          chk_data_d     = '0;
          log_clr        = 1'b1;
        end
      end
      ST_RST: begin
        if (rst_cnt_q == '0) state_d = ST_RUN;
        else                 rst_cnt_d = rst_cnt_q - 32'd1;
      end
      ST_RUN: begin
        // The halt-PC instruction never executes, so its cycle and any store are dropped.
        if (pc_current == HALT_PC) begin
          state_d  = ST_HALTED;
          done_d   = 1'b1;
          halted_d = 1'b1;
          pass_d   = (CHECK_ENABLE == 0) || (chk_seen_q && (chk_data_q == CHECK_DATA));
        end else begin
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_ONE;
          if (cycle_count_q == MAX_LAST) begin
            state_d   = ST_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
          if (we_dm) begin
            if (store_count_q != '1) store_count_d = store_count_q + CNT_ONE;
            last_st_addr_d = alu_out;
            last_st_data_d = wd_dm;
            log_we         = 1'b1;
            if (alu_out == CHECK_ADDR) begin
              chk_seen_d = 1'b1;
              chk_data_d = wd_dm;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rst_cnt_q      <= '0;
      cpu_rst_q      <= 1'b1;
      done_q         <= 1'b0;
      halted_q       <= 1'b0;
      timeout_q      <= 1'b0;
      pass_q         <= 1'b0;
      cycle_count_q  <= '0;
      store_count_q  <= '0;
      last_st_addr_q <= '0;
      last_st_data_q <= '0;
      chk_seen_q     <= 1'b0;
      chk_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      cpu_rst_q      <= cpu_rst_d;
      done_q         <= done_d;
      halted_q       <= halted_d;
      timeout_q      <= timeout_d;
      pass_q         <= pass_d;
      cycle_count_q  <= cycle_count_d;
      store_count_q  <= store_count_d;
      last_st_addr_q <= last_st_addr_d;
      last_st_data_q <= last_st_data_d;
      chk_seen_q     <= chk_seen_d;
      chk_data_q     <= chk_data_d;
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign halted       = halted_q;
  assign timeout      = timeout_q;
  assign pass         = pass_q;
  assign cycle_count  = cycle_count_q;
  assign store_count  = store_count_q;
  assign last_st_addr = last_st_addr_q;
  assign last_st_data = last_st_data_q;

`ifdef STORE_LOG_EN
  mips_store_log #(
    .DEPTH (LOG_DEPTH),
    .IDX_W (LOG_IDX_W)
  ) u_store_log (
    .clk     (clk),
    .rst     (rst),
    .clr     (log_clr),
    .we      (log_we),
    .wr_addr (alu_out),
    .wr_data (wd_dm),
    .rd_idx  (log_idx),
    .rd_addr (log_addr),
    .rd_data (log_data)
  );
`else
  logic log_unused;
  assign log_unused = ^{log_idx, log_we, log_clr};
  assign log_addr   = '0;
  assign log_data   = '0;
`endif

endmodule
